// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter with 2-entry per-source FIFOs; WB_STALL_CNT_EN adds per-source stall counters
package reg_pkg;
  localparam int WORD_SIZE     = 32;
  localparam int NUM_PHYS_REGS = 64;
  localparam int IDXW          = $clog2(NUM_PHYS_REGS);

  typedef struct packed {
    logic                 en;
    logic [IDXW-1:0]      index_in;
    logic [WORD_SIZE-1:0] data_in;
  } RegFileWritePort;
endpackage

module wb_arbiter #(
  parameter int WORD_SIZE     = reg_pkg::WORD_SIZE,
  parameter int NUM_PHYS_REGS = reg_pkg::NUM_PHYS_REGS,
  parameter int NUM_SRC       = 4,
  parameter int NUM_WB_PORTS  = 2,
  localparam int IDXW         = $clog2(NUM_PHYS_REGS),
  localparam int PTRW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_SRC-1:0]                         src_valid,
  output logic [NUM_SRC-1:0]                         src_ready,
  input  logic [NUM_SRC-1:0][IDXW-1:0]               src_index,
  input  logic [NUM_SRC-1:0][WORD_SIZE-1:0]          src_data,
  output reg_pkg::RegFileWritePort [NUM_WB_PORTS-1:0] write_ports
`ifdef WB_STALL_CNT_EN
  ,
  output logic [NUM_SRC-1:0][31:0]                   wb_stall_cnt
`endif
);

  logic [NUM_SRC-1:0][1:0]           cnt;
  logic [NUM_SRC-1:0]                rd_ptr;
  logic [IDXW-1:0]                   mem_idx  [NUM_SRC][2];
  logic [WORD_SIZE-1:0]              mem_data [NUM_SRC][2];
  logic [NUM_SRC-1:0][IDXW-1:0]      head_idx;
  logic [NUM_SRC-1:0][WORD_SIZE-1:0] head_data;
  logic [NUM_SRC-1:0]                push;
  logic [NUM_SRC-1:0]                gnt;
  logic [PTRW-1:0]                   rr_ptr;
  logic [PTRW-1:0]                   last_src;
  reg_pkg::RegFileWritePort [NUM_WB_PORTS-1:0] nxt_ports;
  int                                n_gnt;
  logic                              conflict;

  // Ready comes from the registered count only, so a full FIFO being popped still refuses.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      src_ready[s] = rst && (cnt[s] != 2'd2);
      head_idx[s]  = mem_idx[s][rd_ptr[s]];
      head_data[s] = mem_data[s][rd_ptr[s]];
    end
    push = src_valid & src_ready;
  end

  // Pass 0 covers rr_ptr..NUM_SRC-1, pass 1 wraps to 0..rr_ptr-1.
  always_comb begin
    gnt       = '0;
    nxt_ports = '0;
    n_gnt     = 0;
    conflict  = 1'b0;
    last_src  = rr_ptr;
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if ((p == 0) == (s >= int'(rr_ptr))) begin
          conflict = 1'b0;
          for (int k = 0; k < NUM_WB_PORTS; k++)
            if (k < n_gnt && nxt_ports[k].index_in == head_idx[s]) conflict = 1'b1;
          if (cnt[s] != 2'd0 && n_gnt < NUM_WB_PORTS && !conflict) begin
            for (int k = 0; k < NUM_WB_PORTS; k++)
              if (k == n_gnt) nxt_ports[k] = {1'b1, head_idx[s], head_data[s]};
            gnt[s]   = 1'b1;
            last_src = PTRW'(s);
            n_gnt    = n_gnt + 1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      rd_ptr      <= '0;
      rr_ptr      <= '0;
      write_ports <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        case ({push[s], gnt[s]})
          2'b10:   cnt[s] <= cnt[s] + 2'd1;
          2'b01:   cnt[s] <= cnt[s] - 2'd1;
          default: cnt[s] <= cnt[s];
        endcase
        if (gnt[s]) rd_ptr[s] <= ~rd_ptr[s];
      end
      write_ports <= nxt_ports;
      if (|gnt) rr_ptr <= (last_src == PTRW'(NUM_SRC - 1)) ? '0 : last_src + 1'b1;
    end
  end

  // Tail slot is head + count; a push only happens with count < 2.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push[s]) begin
        mem_idx[s][rd_ptr[s] ^ cnt[s][0]]  <= src_index[s];
        mem_data[s][rd_ptr[s] ^ cnt[s][0]] <= src_data[s];
      end
    end
  end

`ifdef WB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_stall_cnt <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++)
        if (src_valid[s] && !src_ready[s] && wb_stall_cnt[s] != 32'hFFFF_FFFF)
          wb_stall_cnt[s] <= wb_stall_cnt[s] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter; stall-counter scenario built with WB_STALL_CNT_EN
module tb_wb_arbiter;
  import reg_pkg::*;

  localparam int NS = 4;
  localparam int NP = 2;
  localparam int IW = IDXW;
  localparam int DW = WORD_SIZE;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NS-1:0]         src_valid;
  logic [NS-1:0]         src_ready;
  logic [NS-1:0][IW-1:0] src_index;
  logic [NS-1:0][DW-1:0] src_data;
  RegFileWritePort [NP-1:0] write_ports;
`ifdef WB_STALL_CNT_EN
  logic [NS-1:0][31:0]   wb_stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [IW+DW-1:0] sb_q [NS][$];
  logic [IW+DW-1:0] mon_exp;
  int               mon_s;
  logic [DW-1:0]    last12;
  int               seq [NS];
  int               lsu_pushes;
  bit               lsu_low_seen;
  int               lsu_push_before_low;

  wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_index   (src_index),
    .src_data    (src_data),
    .write_ports (write_ports)
`ifdef WB_STALL_CNT_EN
    ,
    .wb_stall_cnt(wb_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: writes are checked against per-source push order, then new pushes are recorded.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NP; k++) begin
        if (write_ports[k].en) begin
          mon_s = int'(write_ports[k].data_in[DW-1:DW-4]);
          checks++;
          if (mon_s >= NS || sb_q[mon_s].size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected port=%0d got=%h", k, write_ports[k]);
          end else begin
            mon_exp = sb_q[mon_s].pop_front();
            if ({write_ports[k].index_in, write_ports[k].data_in} !== mon_exp) begin
              failures++;
              $display("FAIL sb_order port=%0d got=%h exp=%h", k,
                       {write_ports[k].index_in, write_ports[k].data_in}, mon_exp);
            end
          end
          if (write_ports[k].index_in == IW'(12)) last12 = write_ports[k].data_in;
        end
      end
      for (int s = 0; s < NS; s++)
        if (src_valid[s] && src_ready[s]) sb_q[s].push_back({src_index[s], src_data[s]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    for (int s = 0; s < NS; s++) sb_q[s].delete();
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    clear_sb();
    step();
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic run_traffic(input int n, input logic [NS-1:0] mask, input bit same_idx);
    logic [NS-1:0] hs;
    for (int c = 0; c < n; c++) begin
      for (int s = 0; s < NS; s++) begin
        src_valid[s] = mask[s];
        src_index[s] = same_idx ? IW'(7) : IW'(s * 8 + (seq[s] % 8));
        src_data[s]  = {s[3:0], 28'(seq[s])};
      end
      @(negedge clk);
      hs = src_valid & src_ready;
      if (mask[3]) begin
        if (!src_ready[3] && !lsu_low_seen) begin
          lsu_low_seen        = 1'b1;
          lsu_push_before_low = lsu_pushes;
        end
        if (hs[3]) lsu_pushes++;
      end
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) if (hs[s]) seq[s]++;
    end
    src_valid = '0;
  endtask

  task automatic drain_and_check(input string tag);
    src_valid = '0;
    repeat (8) step();
    for (int s = 0; s < NS; s++) begin
      checks++;
      if (sb_q[s].size() != 0) begin
        failures++;
        $display("FAIL %s_lost src=%0d pending=%0d exp=0", tag, s, sb_q[s].size());
      end
    end
    checks++;
    if (write_ports[0].en !== 1'b0 || write_ports[1].en !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_en got=%b%b exp=00", tag, write_ports[1].en, write_ports[0].en);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if (src_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0000", src_ready);
    end
    checks++;
    if (write_ports !== '0) begin
      failures++;
      $display("FAIL reset_ports got=%h exp=0", write_ports);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (src_ready !== 4'b1111) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1111", src_ready);
    end
  endtask

  task automatic test_single();
    RegFileWritePort exp_p;
    exp_p = {1'b1, IW'(5), 32'h0000_DEAD};
    src_valid    = 4'b0001;
    src_index[0] = IW'(5);
    src_data[0]  = 32'h0000_DEAD;
    step();
    src_valid = '0;
    checks++;
    if (write_ports[0].en !== 1'b0 || write_ports[1].en !== 1'b0) begin
      failures++;
      $display("FAIL single_early got=%b%b exp=00", write_ports[1].en, write_ports[0].en);
    end
    step();
    checks++;
    if (write_ports[0] !== exp_p) begin
      failures++;
      $display("FAIL single_p0 got=%h exp=%h", write_ports[0], exp_p);
    end
    checks++;
    if (write_ports[1].en !== 1'b0) begin
      failures++;
      $display("FAIL single_p1 got=%b exp=0", write_ports[1].en);
    end
    step();
    checks++;
    if (write_ports[0].en !== 1'b0 || write_ports[1].en !== 1'b0) begin
      failures++;
      $display("FAIL single_drop got=%b%b exp=00", write_ports[1].en, write_ports[0].en);
    end
  endtask

  task automatic test_all_four();
    RegFileWritePort e0, e1;
    for (int s = 0; s < NS; s++) begin
      src_valid[s] = 1'b1;
      src_index[s] = IW'(20 + s);
      src_data[s]  = {s[3:0], 28'h00000A0};
    end
    step();
    src_valid = '0;
    step();
    e0 = {1'b1, IW'(20), 32'h0000_00A0};
    e1 = {1'b1, IW'(21), 32'h1000_00A0};
    checks++;
    if (write_ports[0] !== e0 || write_ports[1] !== e1) begin
      failures++;
      $display("FAIL rr_first got=%h exp=%h", write_ports, {e1, e0});
    end
    step();
    e0 = {1'b1, IW'(22), 32'h2000_00A0};
    e1 = {1'b1, IW'(23), 32'h3000_00A0};
    checks++;
    if (write_ports[0] !== e0 || write_ports[1] !== e1) begin
      failures++;
      $display("FAIL rr_second got=%h exp=%h", write_ports, {e1, e0});
    end
    step();
    checks++;
    if (write_ports[0].en !== 1'b0 || write_ports[1].en !== 1'b0) begin
      failures++;
      $display("FAIL rr_drop got=%b%b exp=00", write_ports[1].en, write_ports[0].en);
    end
    src_valid    = 4'b1001;
    src_index[0] = IW'(30);
    src_data[0]  = 32'h0000_00B0;
    src_index[3] = IW'(31);
    src_data[3]  = 32'h3000_00B3;
    step();
    src_valid = '0;
    step();
    e0 = {1'b1, IW'(30), 32'h0000_00B0};
    e1 = {1'b1, IW'(31), 32'h3000_00B3};
    checks++;
    if (write_ports[0] !== e0 || write_ports[1] !== e1) begin
      failures++;
      $display("FAIL rr_wrap got=%h exp=%h", write_ports, {e1, e0});
    end
    step();
  endtask

  task automatic test_conflict();
    RegFileWritePort ea, ef;
    ea = {1'b1, IW'(12), 32'h0000_0A12};
    ef = {1'b1, IW'(12), 32'h1000_0F12};
    src_valid    = 4'b0011;
    src_index[0] = IW'(12);
    src_data[0]  = 32'h0000_0A12;
    src_index[1] = IW'(12);
    src_data[1]  = 32'h1000_0F12;
    step();
    src_valid = '0;
    step();
    checks++;
    if (write_ports[0] !== ea || write_ports[1].en !== 1'b0) begin
      failures++;
      $display("FAIL conflict_first got=%h exp_p0=%h exp_p1_en=0", write_ports, ea);
    end
    step();
    checks++;
    if (write_ports[0] !== ef || write_ports[1].en !== 1'b0) begin
      failures++;
      $display("FAIL conflict_second got=%h exp_p0=%h exp_p1_en=0", write_ports, ef);
    end
    step();
    checks++;
    if (last12 !== 32'h1000_0F12) begin
      failures++;
      $display("FAIL conflict_final got=%h exp=%h", last12, 32'h1000_0F12);
    end
  endtask

  task automatic test_backpressure();
    lsu_pushes   = 0;
    lsu_low_seen = 1'b0;
    lsu_push_before_low = -1;
    run_traffic(40, 4'b1111, 1'b0);
    checks++;
    if (lsu_low_seen !== 1'b1 || lsu_push_before_low != 2) begin
      failures++;
      $display("FAIL bp_lsu_ready got_pushes=%0d exp=2", lsu_push_before_low);
    end
    drain_and_check("bp");
  endtask

  task automatic test_reset_mid();
    run_traffic(6, 4'b1111, 1'b0);
    checks++;
    if (write_ports[0].en !== 1'b1 || write_ports[1].en !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy got=%b%b exp=11", write_ports[1].en, write_ports[0].en);
    end
    src_valid = 4'b1111;
    rst = 1'b0;
    clear_sb();
    #1;
    checks++;
    if (write_ports !== '0 || src_ready !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_now ports=%h ready=%b exp=0/0000", write_ports, src_ready);
    end
    step();
    checks++;
    if (src_ready !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_hold got=%b exp=0000", src_ready);
    end
    src_valid = '0;
    rst = 1'b1;
    #1;
    checks++;
    if (src_ready !== 4'b1111) begin
      failures++;
      $display("FAIL midrst_release got=%b exp=1111", src_ready);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (write_ports[0].en !== 1'b0 || write_ports[1].en !== 1'b0) begin
        failures++;
        $display("FAIL midrst_stale cyc=%0d got=%b%b exp=00", c, write_ports[1].en, write_ports[0].en);
      end
    end
  endtask

`ifdef WB_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    checks++;
    if (wb_stall_cnt !== '0) begin
      failures++;
      $display("FAIL stall_reset got=%h exp=0", wb_stall_cnt);
    end
    run_traffic(15, 4'b0101, 1'b1);
    checks++;
    if (wb_stall_cnt[2] !== 32'd7) begin
      failures++;
      $display("FAIL stall_bru got=%0d exp=7", wb_stall_cnt[2]);
    end
    checks++;
    if (wb_stall_cnt[0] !== 32'd6) begin
      failures++;
      $display("FAIL stall_alu got=%0d exp=6", wb_stall_cnt[0]);
    end
    checks++;
    if (wb_stall_cnt[1] !== 32'd0 || wb_stall_cnt[3] !== 32'd0) begin
      failures++;
      $display("FAIL stall_idle got=%0d,%0d exp=0,0", wb_stall_cnt[1], wb_stall_cnt[3]);
    end
    drain_and_check("stall");
  endtask
`endif

  initial begin
    src_valid = '0;
    src_index = '0;
    src_data  = '0;
    last12    = '0;
    for (int s = 0; s < NS; s++) seq[s] = 0;
    test_reset();
    test_single();
    do_reset();
    test_all_four();
    test_conflict();
    do_reset();
    test_backpressure();
    test_reset_mid();
`ifdef WB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
